// File: rtl/i2c_slave_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_ctrl
//  Purpose  : Byte-level I2C target controller. Oversamples SCL/SDA with Clk,
//             detects START / repeated START / STOP, matches a 7-bit address,
//             receives write bytes with ACK/NACK and serves read bytes loaded
//             through a one-cycle Tx_load handshake.
//  Ports    : Clk, Rst_n         - system clock, async active-low reset
//             Scl_i, Sda_i       - asynchronous bus pad inputs
//             Sda_oe             - 1 pulls SDA low (open drain)
//             Ack_en             - ACK (1) / NACK (0) received data bytes
//             Rx_data, Rx_valid  - received byte and its update pulse
//             Tx_data, Tx_load   - byte to send, captured while Tx_load=1
//             Addressed, Rw      - address matched, R/W bit of that match
//             Busy               - bus between START and STOP
//             Stop_det           - STOP pulse
//             Master_nack        - master NACKed a transmitted byte
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oe,
  input  logic       Ack_en,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  input  logic [7:0] Tx_data,
  output logic       Tx_load,
  output logic       Addressed,
  output logic       Rw,
  output logic       Busy,
  output logic       Stop_det,
  output logic       Master_nack
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX_DATA   = 3'd3,
    RX_ACK    = 3'd4,
    TX_DATA   = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers plus one history flop; reset to the idle-bus level.
  // --------------------------------------------------------------------------
  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= Scl_i;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= Sda_i;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  logic scl_rise, scl_fall, start_hit, stop_hit;

  assign scl_rise  =  scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync &  scl_prev;
  // START/STOP need SCL stable high across the SDA transition.
  assign start_hit =  scl_sync & scl_prev &  sda_prev & ~sda_sync;
  assign stop_hit  =  scl_sync & scl_prev & ~sda_prev &  sda_sync;

  // --------------------------------------------------------------------------
  // Controller state
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  // Set on the 8th rise of a byte (or on the master's ACK in TX_ACK); the
  // following SCL fall then performs the slot transition.
  logic       done_q, done_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_d, tx_load_d, stop_d, mnack_d;
  logic       addressed_q, addressed_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       rx_valid_q, tx_load_q, stop_q, mnack_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      done_q      <= 1'b0;
      rx_sr_q     <= 8'd0;
      tx_sr_q     <= 8'd0;
      oe_q        <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      stop_q      <= 1'b0;
      mnack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      oe_q        <= oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      stop_q      <= stop_d;
      mnack_q     <= mnack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    oe_d        = oe_q;
    rx_data_d   = rx_data_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    stop_d      = 1'b0;
    mnack_d     = 1'b0;

    if (start_hit) begin
      state_d     = ADDR;
      cnt_d       = 3'd0;
      done_d      = 1'b0;
      oe_d        = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b1;
    end else if (stop_hit) begin
      state_d     = IDLE;
      cnt_d       = 3'd0;
      done_d      = 1'b0;
      oe_d        = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b0;
      stop_d      = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            rx_sr_d = {rx_sr_q[6:0], sda_sync};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              // The 7 bits already shifted in are the address; SDA is R/W.
              if (rx_sr_q[6:0] == SLV_ADDR) begin
                addressed_d = 1'b1;
                rw_d        = sda_sync;
                done_d      = 1'b1;
                if (sda_sync) begin
                  tx_load_d = 1'b1;
                  tx_sr_d   = Tx_data;
                end
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end else if (scl_fall && done_q) begin
            oe_d    = 1'b1;
            done_d  = 1'b0;
            state_d = ADDR_ACK;
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 3'd0;
            if (rw_q) begin
              oe_d    = ~tx_sr_q[7];
              state_d = TX_DATA;
            end else begin
              oe_d    = 1'b0;
              state_d = RX_DATA;
            end
          end
        end

        RX_DATA: begin
          if (scl_rise) begin
            rx_sr_d = {rx_sr_q[6:0], sda_sync};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = {rx_sr_q[6:0], sda_sync};
              rx_valid_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            oe_d    = Ack_en;
            done_d  = 1'b0;
            state_d = RX_ACK;
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            state_d = RX_DATA;
          end
        end

        TX_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              done_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (done_q) begin
              oe_d    = 1'b0;
              done_d  = 1'b0;
              state_d = TX_ACK;
            end else begin
              // Next bit moves into position 7 and goes straight onto the pin.
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
              oe_d    = ~tx_sr_q[6];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_sync) begin
              tx_load_d = 1'b1;
              tx_sr_d   = Tx_data;
              done_d    = 1'b1;
            end else begin
              mnack_d = 1'b1;
              oe_d    = 1'b0;
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && done_q) begin
            oe_d    = ~tx_sr_q[7];
            cnt_d   = 3'd0;
            done_d  = 1'b0;
            state_d = TX_DATA;
          end
        end

        default: begin
          // IDLE and WAIT_STOP stay passive until START/STOP.
        end
      endcase
    end
  end

  assign Sda_oe      = oe_q;
  assign Rx_data     = rx_data_q;
  assign Rx_valid    = rx_valid_q;
  assign Tx_load     = tx_load_q;
  assign Addressed   = addressed_q;
  assign Rw          = rw_q;
  assign Busy        = busy_q;
  assign Stop_det    = stop_q;
  assign Master_nack = mnack_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave_ctrl
//  Purpose  : Drives the I2C target with a bit-level bus master and compares
//             ACKs, read data and handshake pulse counts against expectations
//             derived from the transaction description.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave_ctrl;

  localparam int         Q   = 10;     // Clk cycles per quarter SCL period
  localparam logic [6:0] SLV = 7'h50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       ack_en = 1'b1;
  logic [7:0] tx_data = 8'd0;

  logic       sda_oe, rx_valid, tx_load, addressed, rw, busy, stop_det, master_nack;
  logic [7:0] rx_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLV_ADDR(SLV)) dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .Scl_i      (scl_m),
    .Sda_i      (sda_line),
    .Sda_oe     (sda_oe),
    .Ack_en     (ack_en),
    .Rx_data    (rx_data),
    .Rx_valid   (rx_valid),
    .Tx_data    (tx_data),
    .Tx_load    (tx_load),
    .Addressed  (addressed),
    .Rw         (rw),
    .Busy       (busy),
    .Stop_det   (stop_det),
    .Master_nack(master_nack)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transaction description shared between the stimulus and the model.
  logic [7:0] wdat [4];
  logic       aen  [4];
  logic [7:0] tx_bytes [8];
  int         load_base = 0;

  // Pulse monitor; the stimulus only takes snapshots of these counters.
  int         rxv_cnt = 0, load_cnt = 0, nack_cnt = 0, stop_cnt = 0, oe_cnt = 0;
  logic [7:0] rx_last = 8'd0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_last = rx_data;
    end
    if (tx_load)     load_cnt++;
    if (master_nack) nack_cnt++;
    if (stop_det)    stop_cnt++;
    if (sda_oe)      oe_cnt++;
    // Present the next queued byte once the previous one has been captured.
    tx_data = tx_bytes[(load_cnt - load_base) & 7];
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    s = sda_line;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
    wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(~m_ack, s);
  endtask

  // One transaction: START, address, n data bytes, optional STOP.
  task automatic xfer(input logic [6:0] addr, input logic rdwr, input int n,
                      input logic do_stop);
    logic       acked, match;
    logic [7:0] d;
    int         rb, lb, nb, ob, sb;
    match     = (addr == SLV);
    rb        = rxv_cnt;
    nb        = nack_cnt;
    ob        = oe_cnt;
    sb        = stop_cnt;
    load_base = load_cnt;
    lb        = load_cnt;
    i2c_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("addressed_at_start", 32'(addressed), 32'd0);
    write_byte({addr, rdwr}, acked);
    check("addr_ack", 32'(acked), 32'(match));
    check("addressed", 32'(addressed), 32'(match));
    if (!match) begin
      write_byte(8'($urandom_range(0, 255)), acked);
      check("nomatch_data_ack", 32'(acked), 32'd0);
      check("nomatch_rx_valid", 32'(rxv_cnt - rb), 32'd0);
    end else if (!rdwr) begin
      check("rw_write", 32'(rw), 32'd0);
      for (int i = 0; i < n; i++) begin
        ack_en = aen[i];
        write_byte(wdat[i], acked);
        check("data_ack", 32'(acked), 32'(aen[i]));
      end
      check("rx_valid_count", 32'(rxv_cnt - rb), 32'(n));
      check("rx_data_last", 32'(rx_last), 32'(wdat[n-1]));
    end else begin
      check("rw_read", 32'(rw), 32'd1);
      for (int i = 0; i < n; i++) begin
        read_byte(i < n - 1, d);
        check("read_data", 32'(d), 32'(tx_bytes[i]));
      end
      check("tx_load_count", 32'(load_cnt - lb), 32'(n));
      check("master_nack_count", 32'(nack_cnt - nb), 32'd1);
      check("sda_released_after_nack", 32'(sda_oe), 32'd0);
    end
    if (do_stop) begin
      i2c_stop();
      check("stop_det_count", 32'(stop_cnt - sb), 32'd1);
      check("addressed_after_stop", 32'(addressed), 32'd0);
      check("busy_after_stop", 32'(busy), 32'd0);
      check("sda_oe_after_stop", 32'(sda_oe), 32'd0);
      if (!match) check("nomatch_never_drives", 32'(oe_cnt - ob), 32'd0);
    end
  endtask

  initial begin
    logic       acked, s;
    logic [6:0] a;
    int         ob;

    for (int i = 0; i < 8; i++) tx_bytes[i] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 8'd0;
      aen[i]  = 1'b1;
    end

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({sda_oe, rx_valid, tx_load, addressed, rw, busy, stop_det, master_nack, rx_data}),
          32'd0);
    rst_n = 1'b1;
    wq();

    // Write 0xA0, 0x3C with ACK.
    wdat[0] = 8'hA0; wdat[1] = 8'h3C; aen[0] = 1'b1; aen[1] = 1'b1;
    xfer(7'h50, 1'b0, 2, 1'b1);

    // Foreign address 0x52.
    xfer(7'h52, 1'b0, 1, 1'b1);

    // Read two bytes, master NACKs the second.
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h5A;
    xfer(7'h50, 1'b1, 2, 1'b1);

    // Write then repeated START into a read.
    wdat[0] = 8'h11; aen[0] = 1'b1;
    xfer(7'h50, 1'b0, 1, 1'b0);
    tx_bytes[0] = 8'hC3; tx_bytes[1] = 8'h3C;
    xfer(7'h50, 1'b1, 2, 1'b1);

    // NACK a received byte.
    wdat[0] = 8'h77; aen[0] = 1'b0;
    xfer(7'h50, 1'b0, 1, 1'b1);

    // Reset in the middle of a transmitted byte.
    tx_bytes[0] = 8'h00;
    load_base = load_cnt;
    i2c_start();
    write_byte({SLV, 1'b1}, acked);
    check("rst_case_addr_ack", 32'(acked), 32'd1);
    bit_xfer(1'b1, s);
    bit_xfer(1'b1, s);
    check("rst_case_driving", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs",
          32'({sda_oe, rx_valid, tx_load, addressed, rw, busy, stop_det, master_nack, rx_data}),
          32'd0);
    wq();
    rst_n = 1'b1;
    ob = oe_cnt;
    for (int i = 0; i < 6; i++) bit_xfer(1'b1, s);
    check("post_reset_passive", 32'(oe_cnt - ob), 32'd0);
    check("post_reset_not_addressed", 32'(addressed), 32'd0);
    wdat[0] = 8'h96; aen[0] = 1'b1;
    xfer(7'h50, 1'b0, 1, 1'b1);

    // Randomized transactions.
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = SLV;
      end else begin
        do a = 7'($urandom_range(0, 127)); while (a == SLV);
      end
      for (int i = 0; i < 4; i++) begin
        wdat[i] = 8'($urandom_range(0, 255));
        aen[i]  = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
      xfer(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
